// File: rtl/sprite_line_sequencer_pkg.sv
// rtl/sprite_line_sequencer_pkg.sv - shared state encoding and word-select constants
package sprseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CULL,
    LOAD,
    STRIDE,
    WB,
    WIDTH,
    DRAW,
    NEXT
  } state_e;

  localparam logic [1:0] WSEL_YH     = 2'd0;
  localparam logic [1:0] WSEL_ADDR   = 2'd1;
  localparam logic [1:0] WSEL_STRIDE = 2'd2;
  localparam logic [1:0] WSEL_WIDTH  = 2'd3;

endpackage

// File: rtl/sprite_line_sequencer_if.sv
// rtl/sprite_line_sequencer_if.sv - datapath strobes and sprite RAM signals
interface sprite_line_sequencer_if;

  logic        i_RAM_WAIT;
  logic [15:0] i_RO_DI;
  logic        i_VEN_n;
  logic        o_CWEN;
  logic        o_VCUL_n;
  logic        o_DELTAX_n;
  logic        o_ALULO_n;
  logic        o_ONTRF;
  logic        o_WB_WE;
  logic [1:0]  o_WSEL;

  modport master (
    input  i_RAM_WAIT, i_RO_DI, i_VEN_n,
    output o_CWEN, o_VCUL_n, o_DELTAX_n, o_ALULO_n, o_ONTRF, o_WB_WE, o_WSEL
  );

  modport slave (
    output i_RAM_WAIT, i_RO_DI, i_VEN_n,
    input  o_CWEN, o_VCUL_n, o_DELTAX_n, o_ALULO_n, o_ONTRF, o_WB_WE, o_WSEL
  );

endinterface

// File: rtl/sprite_line_sequencer_draw_ctr.sv
// rtl/sprite_line_sequencer_draw_ctr.sv - 8-bit loadable pixel down-counter
module sprseq_draw_ctr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  input  logic       hold_i,
  output logic       last_o
);

  logic [7:0] count_q, count_d;

  // Load wins over decrement; a held tick or an exhausted count leaves the value alone.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && !hold_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  // Count register advances only on enabled ticks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else if (tick_i) begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == 8'd1);

endmodule

// File: rtl/sprite_line_sequencer.sv
// rtl/sprite_line_sequencer.sv - per-scanline sprite table walker; SPRSEQ_WRITEBACK_EN adds the WB state
module sprite_line_sequencer
  import sprseq_pkg::*;
#(
  parameter int SPR_COUNT = 32,
  localparam int IDX_W = $clog2(SPR_COUNT)
) (
  input  logic                    i_MCLK,
  input  logic                    i_RST,
  input  logic                    i_CLK5MNCEN,
  input  logic                    i_HSTART,
  sprite_line_sequencer_if.master dp,
  output logic [IDX_W-1:0]        o_SPR_IDX,
  output logic                    o_BUSY,
  output logic                    o_LINE_DONE,
  output logic                    o_OVF
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPR_COUNT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;

  logic wait_w;
  logic last_entry;
  logic done_w;
  logic draw_last;
  logic width_zero;
  logic ctr_load;
  logic ctr_dec;

  logic       cwen_w, vcul_n_w, deltax_n_w, alulo_n_w, ontrf_w, wb_we_w;
  logic [1:0] wsel_w;

  // Upper byte of the RAM word carries nothing this block needs.
  logic unused_rodi_hi;
  assign unused_rodi_hi = ^dp.i_RO_DI[15:8];

  assign wait_w     = dp.i_RAM_WAIT;
  assign last_entry = (idx_q == LAST_IDX);
  // Completion is suppressed while RAM is stalled so the pulse lasts exactly one tick.
  assign done_w     = (state_q == NEXT) && last_entry && !wait_w;
  assign width_zero = (dp.i_RO_DI[7:0] == 8'd0);
  assign ctr_load   = (state_q == WIDTH) && !wait_w;
  assign ctr_dec    = (state_q == DRAW);

  sprseq_draw_ctr u_draw_ctr (
    .clk_i      (i_MCLK),
    .rst_i      (i_RST),
    .tick_i     (i_CLK5MNCEN),
    .load_i     (ctr_load),
    .load_val_i (dp.i_RO_DI[7:0]),
    .dec_i      (ctr_dec),
    .hold_i     (wait_w),
    .last_o     (draw_last)
  );

  // Next state: a line start overrides everything; a RAM stall freezes the walk.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (i_HSTART) begin
      // A start landing on the completion tick is a clean new line, not an overrun.
      if ((state_q != IDLE) && !done_w) begin
        ovf_d = 1'b1;
      end
      state_d = CULL;
      idx_d   = '0;
    end else if (!wait_w) begin
      case (state_q)
        IDLE:   state_d = IDLE;
        CULL:   state_d = dp.i_VEN_n ? NEXT : LOAD;
        LOAD:   state_d = STRIDE;
`ifdef SPRSEQ_WRITEBACK_EN
        STRIDE: state_d = WB;
        WB:     state_d = WIDTH;
`else
        STRIDE: state_d = WIDTH;
`endif
        WIDTH:  state_d = width_zero ? NEXT : DRAW;
        DRAW:   state_d = draw_last ? NEXT : DRAW;
        NEXT: begin
          if (last_entry) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            state_d = CULL;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, index and sticky overrun flag advance on ticks; reset acts on any edge.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (i_CLK5MNCEN) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Strobe decode from the state register, blanked entirely while RAM is stalled.
  always_comb begin
    cwen_w     = 1'b0;
    vcul_n_w   = 1'b1;
    deltax_n_w = 1'b1;
    alulo_n_w  = 1'b1;
    ontrf_w    = 1'b0;
    wb_we_w    = 1'b0;
    wsel_w     = WSEL_YH;
    case (state_q)
      CULL: vcul_n_w = 1'b0;
      LOAD: begin
        wsel_w     = WSEL_ADDR;
        deltax_n_w = 1'b0;
        alulo_n_w  = 1'b0;
      end
      STRIDE: begin
        wsel_w    = WSEL_STRIDE;
        alulo_n_w = 1'b0;
      end
`ifdef SPRSEQ_WRITEBACK_EN
      WB: begin
        wsel_w  = WSEL_ADDR;
        ontrf_w = 1'b1;
        wb_we_w = 1'b1;
      end
`endif
      WIDTH: wsel_w = WSEL_WIDTH;
      DRAW: begin
        wsel_w = WSEL_WIDTH;
        cwen_w = 1'b1;
      end
      default: wsel_w = WSEL_YH;
    endcase
    if (wait_w) begin
      cwen_w     = 1'b0;
      vcul_n_w   = 1'b1;
      deltax_n_w = 1'b1;
      alulo_n_w  = 1'b1;
      ontrf_w    = 1'b0;
      wb_we_w    = 1'b0;
    end
  end

  assign dp.o_CWEN     = cwen_w;
  assign dp.o_VCUL_n   = vcul_n_w;
  assign dp.o_DELTAX_n = deltax_n_w;
  assign dp.o_ALULO_n  = alulo_n_w;
  assign dp.o_WSEL     = wsel_w;
`ifdef SPRSEQ_WRITEBACK_EN
  assign dp.o_ONTRF    = ontrf_w;
  assign dp.o_WB_WE    = wb_we_w;
`else
  assign dp.o_ONTRF    = 1'b0;
  assign dp.o_WB_WE    = 1'b0;
  logic unused_wb_strobes;
  assign unused_wb_strobes = ontrf_w ^ wb_we_w;
`endif

  assign o_SPR_IDX   = idx_q;
  assign o_BUSY      = (state_q != IDLE);
  assign o_LINE_DONE = done_w;
  assign o_OVF       = ovf_q;

endmodule

// File: tb/tb_sprite_line_sequencer.sv
// tb/tb_sprite_line_sequencer.sv - self-checking bench for sprite_line_sequencer
module tb_sprite_line_sequencer;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef SPRSEQ_WRITEBACK_EN
  localparam int WBN = 1;
`else
  localparam int WBN = 0;
`endif

  localparam int K_CULL = 0, K_LOAD = 1, K_STRIDE = 2, K_WB = 3, K_WIDTH = 4, K_DRAW = 5, K_NEXT = 6;

  typedef struct {
    int kind;
    int idx;
  } phase_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          hs  = 1'b0;
  logic [IW-1:0] spr_idx;
  logic          busy, done, ovf;
  logic          vis_tab [N];
  logic [7:0]    wid_tab [N];

  sprite_line_sequencer_if dp ();

  sprite_line_sequencer #(.SPR_COUNT(N)) dut (
    .i_MCLK      (clk),
    .i_RST       (rst),
    .i_CLK5MNCEN (en),
    .i_HSTART    (hs),
    .dp          (dp),
    .o_SPR_IDX   (spr_idx),
    .o_BUSY      (busy),
    .o_LINE_DONE (done),
    .o_OVF       (ovf)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: visible flag from the table while culling, width byte on WSEL=3.
  assign dp.i_VEN_n = dp.o_VCUL_n | ~vis_tab[spr_idx];
  assign dp.i_RO_DI = {8'h5A, (dp.o_WSEL == 2'd3) ? wid_tab[spr_idx] : 8'hC3};

  phase_t ph_q[$];
  logic   m_ovf = 1'b0;
  int     n_chk = 0, n_fail = 0;
  int     c_cwen, c_wbwe, c_done, c_busy, c_idx0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-tick phase list for one whole line, from the sprite table.
  task automatic build_line();
    ph_q.delete();
    for (int i = 0; i < N; i++) begin
      ph_q.push_back('{K_CULL, i});
      if (vis_tab[i]) begin
        ph_q.push_back('{K_LOAD, i});
        ph_q.push_back('{K_STRIDE, i});
        if (WBN == 1) ph_q.push_back('{K_WB, i});
        ph_q.push_back('{K_WIDTH, i});
        for (int w = 0; w < int'(wid_tab[i]); w++) ph_q.push_back('{K_DRAW, i});
      end
      ph_q.push_back('{K_NEXT, i});
    end
  endtask

  task automatic compare(input logic w);
    int k, ix, e_wsel;
    k  = (ph_q.size() > 0) ? ph_q[0].kind : -1;
    ix = (ph_q.size() > 0) ? ph_q[0].idx : 0;
    case (k)
      -1, K_CULL:  e_wsel = 0;
      K_LOAD, K_WB: e_wsel = 1;
      K_STRIDE:    e_wsel = 2;
      K_WIDTH:     e_wsel = 3;
      default:     e_wsel = -1;
    endcase
    chk("cwen",     dp.o_CWEN,     (!w && k == K_DRAW) ? 1 : 0);
    chk("vcul_n",   dp.o_VCUL_n,   (!w && k == K_CULL) ? 0 : 1);
    chk("deltax_n", dp.o_DELTAX_n, (!w && k == K_LOAD) ? 0 : 1);
    chk("alulo_n",  dp.o_ALULO_n,  (!w && (k == K_LOAD || k == K_STRIDE)) ? 0 : 1);
    chk("ontrf",    dp.o_ONTRF,    (!w && k == K_WB) ? 1 : 0);
    chk("wb_we",    dp.o_WB_WE,    (!w && k == K_WB) ? 1 : 0);
    if (e_wsel >= 0) chk("wsel", dp.o_WSEL, e_wsel);
    chk("spr_idx",  spr_idx, ix);
    chk("busy",     busy, (k >= 0) ? 1 : 0);
    chk("line_done", done, (!w && k == K_NEXT && ix == N - 1) ? 1 : 0);
    chk("ovf",      ovf, m_ovf);
  endtask

  task automatic model_update(input logic h, input logic w);
    logic ld;
    ld = (ph_q.size() > 0) && (ph_q[0].kind == K_NEXT) && (ph_q[0].idx == N - 1) && !w;
    if (h) begin
      if (ph_q.size() > 0 && !ld) m_ovf = 1'b1;
      build_line();
    end else if (ph_q.size() > 0 && !w) begin
      void'(ph_q.pop_front());
    end
  endtask

  // One tick: enabled MCLK cycle followed by a disabled one; both are checked.
  task automatic tick(input logic h, input logic w);
    @(negedge clk);
    en = 1'b1; hs = h; dp.i_RAM_WAIT = w;
    #1;
    compare(w);
    if (dp.o_CWEN) c_cwen++;
    if (dp.o_WB_WE) c_wbwe++;
    if (done) c_done++;
    if (busy) c_busy++;
    if (busy && spr_idx == 0) c_idx0++;
    model_update(h, w);
    @(negedge clk);
    en = 1'b0; hs = 1'b0; dp.i_RAM_WAIT = 1'b0;
    #1;
    compare(1'b0);
  endtask

  task automatic clr();
    c_cwen = 0; c_wbwe = 0; c_done = 0; c_busy = 0; c_idx0 = 0;
  endtask

  task automatic run_line(input int bound);
    int n;
    n = 0;
    while (ph_q.size() > 0 && n < bound) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("line_timeout", ph_q.size(), 0);
  endtask

  task automatic set_tab(input logic [3:0] v, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
    for (int i = 0; i < N; i++) vis_tab[i] = v[i];
    wid_tab[0] = w0; wid_tab[1] = w1; wid_tab[2] = w2; wid_tab[3] = w3;
  endtask

  initial begin
    int nd, g;
    dp.i_RAM_WAIT = 1'b0;
    set_tab(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    clr();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    compare(1'b0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Single visible sprite, width 3
    set_tab(4'b0001, 8'd3, 8'd0, 8'd0, 8'd0);
    clr();
    tick(1'b1, 1'b0);
    run_line(100);
    chk("t1_entry_ticks", c_idx0, 8 + WBN);
    chk("t1_cwen_ticks", c_cwen, 3);
    chk("t1_done_pulses", c_done, 1);
    chk("t1_wb_we", c_wbwe, WBN);

    // All culled
    set_tab(4'b0000, 8'd7, 8'd7, 8'd7, 8'd7);
    clr();
    tick(1'b1, 1'b0);
    run_line(100);
    chk("t2_busy_ticks", c_busy, 8);
    chk("t2_done_pulses", c_done, 1);
    chk("t2_cwen_ticks", c_cwen, 0);

    // Width 0 on a visible sprite
    set_tab(4'b0001, 8'd0, 8'd0, 8'd0, 8'd0);
    clr();
    tick(1'b1, 1'b0);
    run_line(100);
    chk("t3_cwen_ticks", c_cwen, 0);
    chk("t3_wb_we", c_wbwe, WBN);
    chk("t3_entry_ticks", c_idx0, 5 + WBN);

    // RAM wait for 2 ticks inside DRAW, width 4
    set_tab(4'b0010, 8'd0, 8'd4, 8'd0, 8'd0);
    clr();
    tick(1'b1, 1'b0);
    nd = 0; g = 0;
    while (ph_q.size() > 0 && g < 100) begin
      if (ph_q[0].kind == K_DRAW && nd == 1) begin
        tick(1'b0, 1'b1);
        chk("t4_idx_wait", spr_idx, 1);
        tick(1'b0, 1'b1);
        nd = 99;
      end else begin
        if (ph_q[0].kind == K_DRAW) nd++;
        tick(1'b0, 1'b0);
      end
      g++;
    end
    chk("t4_cwen_ticks", c_cwen, 4);
    chk("t4_done_pulses", c_done, 1);

    // Line start while drawing entry 2
    set_tab(4'b0111, 8'd1, 8'd1, 8'd5, 8'd0);
    clr();
    tick(1'b1, 1'b0);
    nd = 0; g = 0;
    while (ph_q.size() > 0 && g < 100) begin
      if (ph_q[0].kind == K_DRAW && ph_q[0].idx == 2) begin
        if (nd == 2) break;
        nd++;
      end
      tick(1'b0, 1'b0);
      g++;
    end
    chk("t5_reach", nd, 2);
    tick(1'b1, 1'b0);
    chk("t5_ovf", ovf, 1);
    chk("t5_idx", spr_idx, 0);
    chk("t5_vcul_n", dp.o_VCUL_n, 0);
    chk("t5_no_done", c_done, 0);
    run_line(200);
    chk("t5_done_pulses", c_done, 1);

    // Reset in STRIDE, asserted on a non-enabled edge
    set_tab(4'b0001, 8'd2, 8'd0, 8'd0, 8'd0);
    clr();
    tick(1'b1, 1'b0);
    g = 0;
    while (ph_q.size() > 0 && ph_q[0].kind != K_STRIDE && g < 20) begin
      tick(1'b0, 1'b0);
      g++;
    end
    chk("t6_alulo_stride", dp.o_ALULO_n, 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    ph_q.delete();
    m_ovf = 1'b0;
    compare(1'b0);
    chk("t6_ovf", ovf, 0);
    chk("t6_busy", busy, 0);
    chk("t6_alulo", dp.o_ALULO_n, 1);
    rst = 1'b0;
    clr();
    repeat (3) tick(1'b0, 1'b0);
    chk("t6_idle_busy", c_busy, 0);

    // Line start on the LINE_DONE tick is a fresh line, not an overrun
    set_tab(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    clr();
    tick(1'b1, 1'b0);
    g = 0;
    while (ph_q.size() > 0 && !(ph_q[0].kind == K_NEXT && ph_q[0].idx == N - 1) && g < 20) begin
      tick(1'b0, 1'b0);
      g++;
    end
    tick(1'b1, 1'b0);
    chk("t7_ovf", ovf, 0);
    chk("t7_busy", busy, 1);
    chk("t7_done_first", c_done, 1);
    run_line(100);
    chk("t7_done_pulses", c_done, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_line_sequencer.md
# sprite_line_sequencer

Per-scanline sequencer for the sprite line comparator/address counter datapath. On each line start it walks the sprite attribute table in index order. For each entry it:
- issues the vertical cull compare;
- for visible sprites, loads the source address, adds the stride and writes it back;
- streams the sprite's pixel fetches by holding the counter enable for the sprite width.

It sits between the line timing generator, sprite RAM and the datapath, and is the only driver of the datapath's control strobes.

## Interface
- SPR_COUNT, 32: number of table entries scanned per line (2..256); IDX_W = clog2(SPR_COUNT)
- i_MCLK  in  1  master clock
- i_RST  in  1  synchronous, active-high reset
- i_CLK5MNCEN  in  1  5 MHz clock enable; all state advances only on enabled cycles ("ticks")
- i_HSTART  in  1  line-start pulse, sampled on ticks
- i_RAM_WAIT  in  1  sprite RAM not available this tick (CPU owns it)
- i_RO_DI  in  16  sprite RAM read data; only [7:0] used, in WIDTH state
- i_VEN_n  in  1  datapath visible flag, active low, combinational from current strobes
- o_CWEN, o_VCUL_n, o_DELTAX_n, o_ALULO_n, o_ONTRF  out  1 each  datapath strobes
- o_WB_WE  out  1  sprite RAM write strobe for the address word
- o_WSEL  out  2  word select: 0 Y/height, 1 address, 2 stride, 3 width
- o_SPR_IDX  out  IDX_W  current table entry
- o_BUSY  out  1  scan in progress
- o_LINE_DONE  out  1  one-tick pulse when the scan completes
- o_OVF  out  1  sticky: a line start arrived before the previous scan finished; cleared by reset only

## Operation
- Reset values (outputs):
  - o_CWEN=0, o_VCUL_n=1, o_DELTAX_n=1, o_ALULO_n=1, o_ONTRF=0, o_WB_WE=0
  - o_WSEL=0, o_SPR_IDX=0, o_BUSY=0, o_LINE_DONE=0, o_OVF=0
- Reset state: IDLE.
- States and outputs; any strobe not listed is at its inactive value:
  - IDLE: waits for i_HSTART, then goes to CULL with index 0.
  - CULL: WSEL=0, VCUL_n=0. Samples i_VEN_n on the same tick.
    - i_VEN_n=0: go to LOAD.
    - Otherwise: go to NEXT.
  - LOAD: WSEL=1, DELTAX_n=0, ALULO_n=0. Counter loads the address word.
  - STRIDE: WSEL=2, ALULO_n=0, DELTAX_n=1, VCUL_n=1. Counter becomes counter + stride.
  - WB: WSEL=1, ONTRF=1, WB_WE=1. Writes the advanced address back to the table.
  - WIDTH: WSEL=3. Latches i_RO_DI[7:0] into the draw counter.
    - Width 0: go to NEXT.
    - Otherwise: go to DRAW.
  - DRAW: CWEN=1 for exactly width ticks. The draw counter decrements each tick; at 1, go to NEXT.
  - NEXT:
    - Index = SPR_COUNT-1: pulse LINE_DONE and go to IDLE.
    - Otherwise: increment the index and go to CULL.
- Tick counts: visible sprite = 6 + W ticks (CULL, LOAD, STRIDE, WB, WIDTH, NEXT, plus W DRAW ticks); culled = 2 ticks.
- i_RAM_WAIT=1 on a tick:
  - The state does not advance.
  - All strobes are forced inactive combinationally; WSEL and SPR_IDX are held.
  - In DRAW, the draw counter does not decrement.
- i_HSTART while busy:
  - Set o_OVF.
  - Abort and restart at CULL, index 0. No LINE_DONE for the aborted line.
  - Takes priority over RAM_WAIT and over every transition.
- i_HSTART on the same tick as the LINE_DONE pulse: counts as a new start, not an overflow.
- The index wraps only through IDLE, never mid-scan.
- o_BUSY=1 in every state except IDLE.

## Timing
- Strobes and selects are decoded from the state register. They are stable for the whole tick and change only after an enabled edge, apart from the RAM_WAIT gating.
- The cull decision uses i_VEN_n in the same tick as VCUL_n=0; no extra compare latency.
- Counter load/add lands on the tick edge ending LOAD/STRIDE, so WB drives the updated counter.
- Latencies:
  - i_HSTART tick → CULL on the next tick.
  - Last NEXT → LINE_DONE high for that single tick; IDLE on the next tick.
- Nothing changes on non-enabled MCLK cycles. i_RST acts on any MCLK edge, independent of the enable.

## Configuration
- SPRSEQ_WRITEBACK_EN defined: WB state present, as above.
- SPRSEQ_WRITEBACK_EN undefined:
  - WB is removed; STRIDE goes directly to WIDTH.
  - o_ONTRF and o_WB_WE are tied 0; the table stays static.
  - Visible sprite = 5 + W ticks.

## Structure
- Package sprseq_pkg holds:
  - state enum (IDLE, CULL, LOAD, STRIDE, WB, WIDTH, DRAW, NEXT);
  - WSEL constants WSEL_YH=0, WSEL_ADDR=1, WSEL_STRIDE=2, WSEL_WIDTH=3.
- One sub-module, sprseq_draw_ctr: 8-bit loadable down-counter with tick enable, hold, and last-count flag.

## Test plan
- Single visible sprite, width 3 → strobe sequence CULL, LOAD, STRIDE, WB, WIDTH, then CWEN high for 3 ticks, NEXT. 9 ticks for the entry.
- SPR_COUNT=4, all culled (i_VEN_n=1) → LINE_DONE exactly 8 ticks after the first CULL tick; CWEN never high.
- Width 0 on a visible sprite → goes WIDTH → NEXT with no CWEN tick; WB_WE pulse still seen.
- i_RAM_WAIT held 2 ticks during DRAW with width 4 → CWEN low during the wait; total CWEN ticks still 4; index unchanged.
- i_HSTART at index 2 mid-DRAW → o_OVF=1; next tick is CULL, index 0; no LINE_DONE for the aborted line.
- i_RST mid-STRIDE → all outputs at their reset values on the next MCLK edge; IDLE until the next i_HSTART.
